// File: rtl/mmio_event_hub.sv
// mmio_event_hub: memory-mapped sensor front end.
// Each channel is synchronised, debounced and rising-edge detected into a
// sticky pending bit plus a saturating event counter. The CPU reads status
// through a 16-word read window and acks events through a 16-word write window.
// Optional build macro: EVENT_HUB_OVERFLOW_EN adds a sticky per-channel
// overflow flag (missed ack or saturated counter), read back as bit2.

module mmio_event_hub_lane #(
  parameter int DEBOUNCE_CYCLES = 30000,
  parameter int CNT_W           = 8,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sense,
  input  logic             clr_pend,
  input  logic             clr_cnt,
  input  logic             clr_ovf,
  output logic             level,
  output logic             pending,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);
  localparam int   DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  // Raw pin value that means "inactive"; synchroniser resets to it.
  localparam logic IDLE_RAW = (ACTIVE_LOW != 0);

  logic [1:0]      sync;
  logic [DB_W-1:0] db_cnt;
  logic            act, toggle, rise, sat;

  assign act    = sync[1] ^ IDLE_RAW;
  assign toggle = (act != level) && (db_cnt == DB_W'(DEBOUNCE_CYCLES));
  assign rise   = toggle && !level;
  assign sat    = &count;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clock) begin
    if (!reset_n) sync <= {2{IDLE_RAW}};
    else          sync <= {sync[0], sense};
  end

  // Debounce: count consecutive disagreeing cycles, flip level once stable.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (act != level) begin
      if (toggle) begin
        db_cnt <= '0;
        level  <= ~level;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Sticky pending; an event in the same cycle beats an ack.
  always_ff @(posedge clock) begin
    if (!reset_n)      pending <= 1'b0;
    else if (rise)     pending <= 1'b1;
    else if (clr_pend) pending <= 1'b0;
  end

  // Saturating event counter; a clear racing an event leaves a count of 1.
  always_ff @(posedge clock) begin
    if (!reset_n)     count <= '0;
    else if (rise)    count <= clr_cnt ? CNT_W'(1) : (sat ? count : count + 1'b1);
    else if (clr_cnt) count <= '0;
  end

`ifdef EVENT_HUB_OVERFLOW_EN
  // Overflow: event arrived while unacked or with the counter pinned.
  always_ff @(posedge clock) begin
    if (!reset_n)                  overflow <= 1'b0;
    else if (rise && (pending || sat)) overflow <= 1'b1;
    else if (clr_ovf)              overflow <= 1'b0;
  end
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = clr_ovf;
  assign overflow       = 1'b0;
`endif
endmodule

module mmio_event_hub #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 30000,
  parameter int CNT_W           = 8,
  parameter int ACTIVE_LOW      = 1,
  parameter int READ_BASE       = 0,
  parameter int ACK_BASE        = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] sense,
  input  logic [11:0]         addr,
  input  logic                wren,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                hit,
  output logic                pending_any,
  output logic [CHANNELS-1:0] level
);
  localparam logic [7:0] RD_PAGE  = 8'(READ_BASE >> 4);
  localparam logic [7:0] ACK_PAGE = 8'(ACK_BASE >> 4);

  logic [3:0]                      word;
  logic                            ack_hit;
  logic [CHANNELS-1:0]             pending, overflow, clr_pend, clr_cnt, clr_ovf;
  logic [CHANNELS-1:0][CNT_W-1:0]  count;
  logic [CHANNELS-1:0][31:0]       status;
  logic                            unused_wdata;

  assign word         = addr[3:0];
  assign hit          = (addr[11:4] == RD_PAGE);
  assign ack_hit      = wren && (addr[11:4] == ACK_PAGE);
  assign pending_any  = |pending;
  assign unused_wdata = ^wdata;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      // Word i acks individual fields; word 15 is a bulk pending-clear mask.
      assign clr_pend[i] = ack_hit && ((word == 4'(i) && wdata[0]) || (word == 4'hF && wdata[i]));
      assign clr_cnt[i]  = ack_hit && (word == 4'(i)) && wdata[1];
      assign clr_ovf[i]  = ack_hit && (word == 4'(i)) && wdata[2];
      assign status[i]   = 32'({count[i], 5'b0, overflow[i], level[i], pending[i]});

      mmio_event_hub_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_lane (
        .clock   (clock),
        .reset_n (reset_n),
        .sense   (sense[i]),
        .clr_pend(clr_pend[i]),
        .clr_cnt (clr_cnt[i]),
        .clr_ovf (clr_ovf[i]),
        .level   (level[i]),
        .pending (pending[i]),
        .overflow(overflow[i]),
        .count   (count[i])
      );
    end
  endgenerate

  // Combinational read mux: per-channel status, pending mask at word 15.
  always_comb begin
    rdata = '0;
    if (hit) begin
      if (word == 4'hF) rdata = 32'(pending);
      else
        for (int i = 0; i < CHANNELS; i++)
          if (word == 4'(i)) rdata = status[i];
    end
  end
endmodule
